// File: rtl/cmd_bridge.sv
// rtl/cmd_bridge.sv - byte-stream command bridge driving a Wishbone master
//
// Receives a command frame on the rx byte stream, runs one Wishbone cycle,
// then returns a status byte (plus read data for successful reads) on tx.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rx_data, rx_valid, rx_ready command bytes in (header + optional 4 data)
//   tx_data, tx_valid, tx_ready response bytes out (status + optional 4 data)
//   wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o   Wishbone master outputs
//   wb_dat_i, wb_ack_i                                Wishbone master inputs
module cmd_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_we_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    typedef enum logic [1:0] {RX_HDR, RX_DATA, BUS, TX} state_t;

    // Last stb cycle index before the cycle is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [2:0]  byte_cnt;   // rx data byte index, then tx response byte index
    logic [7:0]  tmo_cnt;
    logic        timed_out;
    logic [31:0] rd_data;
    logic        rx_fire, tx_fire, tx_last;
    logic [7:0]  resp_cur, resp_next;

    function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                             input logic status,
                                             input logic [31:0] data);
        case (idx)
            3'd1:    resp_byte = data[7:0];
            3'd2:    resp_byte = data[15:8];
            3'd3:    resp_byte = data[23:16];
            3'd4:    resp_byte = data[31:24];
            default: resp_byte = {7'd0, status};
        endcase
    endfunction

    // rx_ready is gated by rst so it reads 0 for the whole reset pulse.
    assign rx_ready  = !rst && (state == RX_HDR || state == RX_DATA);
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    // Writes and timeouts answer with the status byte only.
    assign tx_last   = (wb_we_o || timed_out) ? (byte_cnt == 3'd0) : (byte_cnt == 3'd4);
    assign resp_cur  = resp_byte(byte_cnt, timed_out, rd_data);
    assign resp_next = resp_byte(byte_cnt + 3'd1, timed_out, rd_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_HDR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_HDR:  if (rx_fire) state_next = rx_data[7] ? RX_DATA : BUS;
            RX_DATA: if (rx_fire && byte_cnt == 3'd3) state_next = BUS;
            BUS:     if (wb_ack_i || tmo_cnt == TMO_LAST) state_next = TX;
            TX:      if (tx_fire && tx_last) state_next = RX_HDR;
            default: state_next = RX_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= 3'd0;
            tmo_cnt   <= 8'd0;
            timed_out <= 1'b0;
            rd_data   <= 32'd0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= 7'd0;
            wb_dat_o  <= 32'd0;
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
        end else begin
            case (state)
                RX_HDR: if (rx_fire) begin
                    wb_we_o  <= rx_data[7];
                    wb_adr_o <= rx_data[6:0];
                    byte_cnt <= 3'd0;
                    if (!rx_data[7]) begin
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        tmo_cnt  <= 8'd0;
                    end
                end
                RX_DATA: if (rx_fire) begin
                    // Little-endian: first data byte lands in bits 7:0.
                    wb_dat_o[{byte_cnt[1:0], 3'b000} +: 8] <= rx_data;
                    if (byte_cnt == 3'd3) begin
                        byte_cnt <= 3'd0;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        tmo_cnt  <= 8'd0;
                    end else begin
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                BUS: begin
                    byte_cnt <= 3'd0;
                    if (wb_ack_i) begin
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        rd_data   <= wb_dat_i;
                        timed_out <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        timed_out <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                TX: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= resp_cur;
                    end else if (tx_ready) begin
                        if (tx_last) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= 3'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                            tx_data  <= resp_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_bridge.sv
// tb/tb_cmd_bridge.sv - directed self-checking bench for cmd_bridge
module tb_cmd_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        wb_stb_o, wb_cyc_o, wb_we_o;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i;

    int n_vec = 0;
    int n_err = 0;

    // Slave model: ack on the ack_after-th stb cycle (0 = never).
    int          ack_after = 0;
    logic [31:0] ack_data = 32'd0;
    int          stb_run = 0;
    bit          stall_mode = 1'b0;
    int          wait_cnt = 0;

    // Monitor state
    logic [7:0]  tx_q[$];
    int          stb_starts = 0, cur_len = 0, last_len = 0;
    int          wb_unstable = 0, cyc_err = 0, tx_unstable = 0;
    logic        rec_we = 1'b0;
    logic [6:0]  rec_adr = 7'd0;
    logic [31:0] rec_dat = 32'd0;
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'd0;

    cmd_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    assign wb_dat_i = ack_data;
    assign wb_ack_i = wb_stb_o && (ack_after != 0) && (stb_run + 1 == ack_after);

    always @(posedge clk) begin
        if (wb_stb_o) stb_run <= stb_run + 1;
        else          stb_run <= 0;
    end

    // tx_ready: always high, or held low 5 clocks before each byte.
    always @(negedge clk) begin
        if (!stall_mode) tx_ready = 1'b1;
        else if (tx_valid) begin
            if (wait_cnt == 5) begin tx_ready = 1'b1; wait_cnt = 0; end
            else begin tx_ready = 1'b0; wait_cnt++; end
        end else begin
            tx_ready = 1'b0;
            wait_cnt = 0;
        end
    end

    // Sample 1ns before each rising edge: values seen here are the ones the edge uses.
    always @(negedge clk) begin
        #4;
        if (wb_stb_o) begin
            cur_len++;
            if (cur_len == 1) begin
                stb_starts++;
                rec_we  = wb_we_o;
                rec_adr = wb_adr_o;
                rec_dat = wb_dat_o;
            end else if (wb_we_o !== rec_we || wb_adr_o !== rec_adr || wb_dat_o !== rec_dat) begin
                wb_unstable++;
            end
        end else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        if (wb_cyc_o !== wb_stb_o) cyc_err++;
        if (hold_prev && (tx_valid !== 1'b1 || tx_data !== hold_data)) tx_unstable++;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        hold_prev = tx_valid && !tx_ready;
        hold_data = tx_data;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (rx_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte %02h: rx_ready got %b want 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int base, input int n);
        int c = 0;
        while (tx_q.size() < base + n && c < 800) begin @(negedge clk); c++; end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({wb_stb_o, wb_cyc_o, wb_we_o, tx_valid, rx_ready} !== 5'b0) begin
            n_err++; $display("FAIL reset ctrl: got %b want 00000", {wb_stb_o, wb_cyc_o, wb_we_o, tx_valid, rx_ready});
        end
        n_vec++;
        if (wb_adr_o !== 7'd0) begin n_err++; $display("FAIL reset adr: got %h want 00", wb_adr_o); end
        n_vec++;
        if (wb_dat_o !== 32'd0) begin n_err++; $display("FAIL reset dat: got %h want 0", wb_dat_o); end
        n_vec++;
        if (tx_data !== 8'd0) begin n_err++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset rx_ready after: got %b want 1", rx_ready); end
    endtask

    task automatic test_write;
        int base = tx_q.size();
        int starts = stb_starts;
        logic [7:0] frame [5];
        frame = '{8'h95, 8'h78, 8'h56, 8'h34, 8'h12};
        ack_after = 2;
        for (int i = 0; i < 5; i++) send_byte(frame[i]);
        n_vec++;
        if (wb_stb_o !== 1'b1) begin n_err++; $display("FAIL write stb after last byte: got %b want 1", wb_stb_o); end
        wait_tx(base, 1);
        n_vec++;
        if (stb_starts - starts !== 1) begin n_err++; $display("FAIL write stb count: got %0d want 1", stb_starts - starts); end
        n_vec++;
        if (last_len !== 2) begin n_err++; $display("FAIL write stb len: got %0d want 2", last_len); end
        n_vec++;
        if ({rec_we, rec_adr, rec_dat} !== {1'b1, 7'h15, 32'h12345678}) begin
            n_err++; $display("FAIL write bus: got we=%b adr=%h dat=%h want we=1 adr=15 dat=12345678", rec_we, rec_adr, rec_dat);
        end
        n_vec++;
        if (tx_q.size() - base !== 1) begin n_err++; $display("FAIL write tx count: got %0d want 1", tx_q.size() - base); end
        else begin
            n_vec++;
            if (tx_q[base] !== 8'h00) begin n_err++; $display("FAIL write status: got %h want 00", tx_q[base]); end
        end
        n_vec++;
        if ({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {1'b0, 1'b1, 7'h15, 32'h12345678}) begin
            n_err++; $display("FAIL write idle hold: got stb=%b we=%b adr=%h dat=%h want 0 1 15 12345678", wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
        end
    endtask

    task automatic test_read;
        int base = tx_q.size();
        int starts = stb_starts;
        logic [7:0] exp_tx [5];
        logic [7:0] got;
        exp_tx = '{8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
        ack_after = 3;
        ack_data  = 32'hCAFEBABE;
        send_byte(8'h10);
        wait_tx(base, 5);
        n_vec++;
        if (stb_starts - starts !== 1 || last_len !== 3) begin
            n_err++; $display("FAIL read stb: got starts=%0d len=%0d want 1 3", stb_starts - starts, last_len);
        end
        n_vec++;
        if ({rec_we, rec_adr} !== {1'b0, 7'h10}) begin n_err++; $display("FAIL read bus: got we=%b adr=%h want 0 10", rec_we, rec_adr); end
        n_vec++;
        if (tx_q.size() - base !== 5) begin n_err++; $display("FAIL read tx count: got %0d want 5", tx_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== exp_tx[i]) begin n_err++; $display("FAIL read tx[%0d]: got %h want %h", i, got, exp_tx[i]); end
        end
    endtask

    task automatic test_timeout;
        int base = tx_q.size();
        logic [7:0] exp_tx [5];
        logic [7:0] got;
        exp_tx = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        ack_after = 0;
        send_byte(8'h20);
        wait_tx(base, 1);
        n_vec++;
        if (last_len !== 16) begin n_err++; $display("FAIL timeout stb len: got %0d want 16", last_len); end
        n_vec++;
        if (tx_q.size() - base !== 1) begin n_err++; $display("FAIL timeout tx count: got %0d want 1", tx_q.size() - base); end
        else begin
            n_vec++;
            if (tx_q[base] !== 8'h01) begin n_err++; $display("FAIL timeout status: got %h want 01", tx_q[base]); end
        end
        base      = tx_q.size();
        ack_after = 1;
        ack_data  = 32'h11223344;
        send_byte(8'h33);
        wait_tx(base, 5);
        n_vec++;
        if (tx_q.size() - base !== 5) begin n_err++; $display("FAIL after-timeout tx count: got %0d want 5", tx_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== exp_tx[i]) begin n_err++; $display("FAIL after-timeout tx[%0d]: got %h want %h", i, got, exp_tx[i]); end
        end
    endtask

    task automatic test_comb_ack;
        int base = tx_q.size();
        logic [7:0] got;
        ack_after = 1;
        ack_data  = 32'd0;
        send_byte(8'h7F);
        n_vec++;
        if (wb_stb_o !== 1'b1) begin n_err++; $display("FAIL comb stb first cycle: got %b want 1", wb_stb_o); end
        wait_tx(base, 5);
        n_vec++;
        if (last_len !== 1 || rec_adr !== 7'h7F) begin n_err++; $display("FAIL comb stb: got len=%0d adr=%h want 1 7f", last_len, rec_adr); end
        n_vec++;
        if (tx_q.size() - base !== 5) begin n_err++; $display("FAIL comb tx count: got %0d want 5", tx_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== 8'h00) begin n_err++; $display("FAIL comb tx[%0d]: got %h want 00", i, got); end
        end
    endtask

    task automatic test_tx_stall;
        int base = tx_q.size();
        int unst = tx_unstable;
        logic [7:0] exp_tx [5];
        logic [7:0] got;
        exp_tx = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        stall_mode = 1'b1;
        ack_after  = 2;
        ack_data   = 32'hA1B2C3D4;
        send_byte(8'h05);
        wait_tx(base, 5);
        stall_mode = 1'b0;
        n_vec++;
        if (tx_unstable - unst !== 0) begin n_err++; $display("FAIL stall tx stability: got %0d violations want 0", tx_unstable - unst); end
        n_vec++;
        if (tx_q.size() - base !== 5) begin n_err++; $display("FAIL stall tx count: got %0d want 5", tx_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== exp_tx[i]) begin n_err++; $display("FAIL stall tx[%0d]: got %h want %h", i, got, exp_tx[i]); end
        end
    endtask

    task automatic test_ignore_busy;
        int base = tx_q.size();
        int starts = stb_starts;
        logic [7:0] exp_tx [5];
        logic [7:0] got;
        exp_tx = '{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        ack_after = 8;
        ack_data  = 32'h0BADF00D;
        send_byte(8'h21);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rx_ready !== 1'b0) begin n_err++; $display("FAIL busy rx_ready: got %b want 0", rx_ready); end
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        wait_tx(base, 5);
        repeat (20) @(negedge clk);
        n_vec++;
        if (stb_starts - starts !== 1) begin n_err++; $display("FAIL busy byte buffered: got %0d stb cycles want 1", stb_starts - starts); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== exp_tx[i]) begin n_err++; $display("FAIL busy tx[%0d]: got %h want %h", i, got, exp_tx[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        int starts = stb_starts;
        logic [7:0] exp_tx [5];
        logic [7:0] got;
        exp_tx = '{8'h00, 8'h34, 8'h12, 8'hAA, 8'h55};
        ack_after = 2;
        send_byte(8'h8A);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({rx_ready, wb_we_o, wb_adr_o, wb_dat_o, tx_valid, wb_stb_o} !== 42'd0) begin
            n_err++; $display("FAIL mid-frame reset outputs: got rdy=%b we=%b adr=%h dat=%h txv=%b stb=%b want all 0",
                              rx_ready, wb_we_o, wb_adr_o, wb_dat_o, tx_valid, wb_stb_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stb_starts - starts !== 0) begin n_err++; $display("FAIL mid-frame reset stb: got %0d cycles want 0", stb_starts - starts); end
        base     = tx_q.size();
        ack_data = 32'h55AA1234;
        send_byte(8'h10);
        wait_tx(base, 5);
        n_vec++;
        if ({rec_we, rec_adr} !== {1'b0, 7'h10}) begin n_err++; $display("FAIL post-reset bus: got we=%b adr=%h want 0 10", rec_we, rec_adr); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            n_vec++;
            if (got !== exp_tx[i]) begin n_err++; $display("FAIL post-reset tx[%0d]: got %h want %h", i, got, exp_tx[i]); end
        end
        // Reset in the middle of a bus cycle.
        ack_after = 0;
        send_byte(8'h40);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({wb_stb_o, wb_cyc_o, wb_adr_o} !== 9'd0) begin
            n_err++; $display("FAIL mid-bus reset: got stb=%b cyc=%b adr=%h want 0 0 00", wb_stb_o, wb_cyc_o, wb_adr_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bus_integrity;
        n_vec++;
        if (wb_unstable !== 0) begin n_err++; $display("FAIL wb stability: got %0d violations want 0", wb_unstable); end
        n_vec++;
        if (cyc_err !== 0) begin n_err++; $display("FAIL cyc/stb pairing: got %0d violations want 0", cyc_err); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_comb_ack();
        test_tx_stall();
        test_ignore_busy();
        test_reset_mid();
        test_bus_integrity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cmd_bridge.md
CMD_BRIDGE -- requirements
Module: cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max bus-cycle length in clocks without ack (legal range 1..255).
REQ-002 SHALL have ports clk (input, 1) as the sole clock and rst (input, 1) as the reset; reset is asynchronous and active-high.
REQ-003 SHALL have rx_data input 8: command byte stream from the serial receiver.
REQ-004 SHALL have rx_valid input 1: rx_data holds a valid byte.
REQ-005 SHALL have rx_ready output 1: the bridge accepts a byte this cycle.
REQ-006 SHALL have tx_data output 8: response byte to the serial transmitter.
REQ-007 SHALL have tx_valid output 1: tx_data holds a valid byte.
REQ-008 SHALL have tx_ready input 1: the transmitter accepts a byte this cycle.
REQ-009 SHALL have wishbone master outputs wb_stb_o (1), wb_cyc_o (1), wb_we_o (1), wb_adr_o (7) and wb_dat_o (32).
REQ-010 SHALL have wishbone master inputs wb_dat_i (32) and wb_ack_i (1).

Function
REQ-011 SHALL transfer a byte on any rising clk edge where valid and ready are both high, on both rx and tx.
REQ-012 SHALL decode the frame header byte as bit7=write, bits6:0=address; a write header is followed by 4 data bytes, little-endian; a read header has no payload.
REQ-013 SHALL implement states RX_HDR, RX_DATA, BUS, TX.
  - RX_HDR->RX_DATA on write header; RX_HDR->BUS on read header.
  - RX_DATA->BUS on the 4th data byte.
  - BUS->TX on ack or timeout.
  - TX->RX_HDR on the last response byte.
REQ-014 SHALL drive rx_ready=1 only in RX_HDR/RX_DATA, and 0 while rst is high.
REQ-015 SHALL assert wb_stb_o and wb_cyc_o together in the clock after the final frame byte is accepted, with wb_adr_o, wb_we_o and wb_dat_o stable for the whole cycle.
REQ-016 SHALL sample wb_ack_i on each edge while stb is high; on ack it SHALL capture wb_dat_i, and stb/cyc SHALL be low in the next cycle.
REQ-017 SHALL accept an ack that is already high in the first stb cycle (combinational ack), giving a one-clock stb pulse.
REQ-018 SHALL count stb-high cycles in an 8-bit counter; if TIMEOUT cycles elapse without ack, stb/cyc SHALL drop after exactly TIMEOUT cycles and status SHALL be 0x01.
REQ-019 SHALL send response status byte 0x00 (ack) or 0x01 (timeout) first; a successful read SHALL then send 4 data bytes, LSB first; writes and timed-out reads SHALL send the status byte only.
REQ-020 SHALL raise tx_valid in the cycle after entering TX and hold tx_data stable while tx_valid=1 and tx_ready=0; consecutive bytes SHALL go out back-to-back when tx_ready stays high.
REQ-021 SHALL ignore rx_valid outside RX_HDR/RX_DATA and SHALL NOT buffer those bytes.
REQ-022 SHALL keep wb_dat_o at the last write data and wb_we_o/wb_adr_o at the last frame values when idle.

Reset
REQ-023 SHALL, on rst assertion, immediately force state=RX_HDR, byte counter=0, timeout counter=0, and all outputs to 0 (wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, tx_valid, tx_data, rx_ready), at any point, including mid-frame and mid-bus-cycle.
REQ-024 SHALL, after rst deasserts, accept the next byte as a fresh header; partially received frames SHALL be discarded.

Verification
REQ-025 SHALL pass: rx 0x95,0x78,0x56,0x34,0x12, ack after 1 clock -> stb with we=1, adr=0x15, dat=0x12345678; tx 0x00 only.
REQ-026 SHALL pass: rx 0x10, ack on 3rd stb cycle with dat_i=0xCAFEBABE -> stb high exactly 3 cycles, we=0, adr=0x10; tx 0x00,0xBE,0xBA,0xFE,0xCA.
REQ-027 SHALL pass: rx 0x20, ack never -> stb high exactly 16 cycles; tx 0x01 only; next frame processed normally.
REQ-028 SHALL pass: rx 0x7F, ack combinationally high with dat_i=0 -> stb high exactly 1 cycle; tx 0x00,0x00,0x00,0x00,0x00.
REQ-029 SHALL pass: read with tx_ready held low 5 clocks per byte -> tx_data/tx_valid stable until each handshake; no byte lost or duplicated.
REQ-030 SHALL pass: rst pulsed after 2 of 4 write data bytes -> all outputs 0 during reset, no stb, and subsequent frame 0x10 yields a correct read response.
